axi_read_slave_mem: RTL and testbench

//  AXI4 read-channel responder backed by a word-addressed memory array (instruction ROM / boot RAM).

---
 rtl/axi_read_slave_mem_pkg.sv | 30 +++
 rtl/axi_burst_addr_gen.sv | 57 +++++
 rtl/axi_read_slave_mem.sv | 207 ++++++++++++++++++++
 tb/tb_axi_read_slave_mem.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_read_slave_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_read_slave_mem_pkg
// Description : Shared AXI read-channel encodings for the read slave memory
//               and its address generator.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_read_slave_mem_pkg;

    // Response encodings carried on RRESP
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // Burst type encodings carried on ARBURST
    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    // Beat size encoding for a 32-bit beat
    localparam logic [2:0] AXI_SIZE_4B = 3'd2;

    // True when the requested beat size fits within one data word
    function automatic logic axi_size_legal(input logic [2:0] size, input logic [2:0] max_size);
        return (size <= max_size);
    endfunction

endpackage : axi_read_slave_mem_pkg
`default_nettype wire

// File: rtl/axi_burst_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : axi_burst_addr_gen
// Description : Combinational per-beat address decode for the read slave:
//               next beat address, memory word index, range check and the
//               response code the beat must carry.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_burst_addr_gen
    import axi_read_slave_mem_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    MEM_DEPTH  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    IDX_WIDTH  = 10
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [2:0]            size,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] next_addr,
    output logic [IDX_WIDTH-1:0]  word_idx,
    output logic                  in_range,
    output logic [1:0]            resp_code
);

    localparam int                  c_OFF_BITS = $clog2(DATA_WIDTH / 8);
    localparam logic [2:0]          c_MAX_SIZE = 3'(c_OFF_BITS);
    localparam logic [ADDR_WIDTH:0] c_SPAN     = (ADDR_WIDTH + 1)'(MEM_DEPTH * (DATA_WIDTH / 8));

    logic [ADDR_WIDTH-1:0] w_offset;

    assign w_offset = addr - BASE_ADDR;
    // Byte-offset bits inside a word are dropped: a full word is always returned
    assign word_idx = IDX_WIDTH'(w_offset >> c_OFF_BITS);
    assign in_range = (addr >= BASE_ADDR) && ({1'b0, w_offset} < c_SPAN);

    // FIXED holds the address; INCR (and WRAP, which only errors) steps by the beat size
    always_comb begin
        next_addr = addr;
        if (burst != AXI_BURST_FIXED) begin
            next_addr = addr + (ADDR_WIDTH'(1) << size);
        end
    end

    // Protocol errors take priority over the address decode
    always_comb begin
        resp_code = AXI_RESP_OKAY;
        if ((burst == AXI_BURST_WRAP) || (burst == 2'b11) || !axi_size_legal(size, c_MAX_SIZE)) begin
            resp_code = AXI_RESP_SLVERR;
        end else if (!in_range) begin
            resp_code = AXI_RESP_DECERR;
        end
    end

endmodule : axi_burst_addr_gen
`default_nettype wire

// File: rtl/axi_read_slave_mem.sv
`default_nettype none
// ============================================================================
// Module      : axi_read_slave_mem
// Description : AXI4 read-channel responder backed by a word-addressed memory.
//               One outstanding burst, programmable AR->R latency, R-channel
//               backpressure with held data, per-beat decode errors.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_read_slave_mem
    import axi_read_slave_mem_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    MEM_DEPTH    = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
    parameter int                    READ_LATENCY = 2,
    parameter string                 INIT_FILE    = ""
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic [7:0]            arlen,
    input  logic [2:0]            arsize,
    input  logic [1:0]            arburst,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready
);

    localparam int         c_IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [3:0] c_LAT   = 4'(READ_LATENCY);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_BURST = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic                  r_arready;
    logic                  r_rvalid;
    logic                  r_rlast;
    logic [1:0]            r_rresp;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [ADDR_WIDTH-1:0] r_addr;      // address of the next beat to be loaded
    logic [7:0]            r_len;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic [7:0]            r_beat_cnt;  // index of the beat currently presented
    logic [3:0]            r_lat_cnt;

    logic [DATA_WIDTH-1:0] r_mem [0:MEM_DEPTH-1];

    logic                  w_ar_hs;
    logic                  w_load;
    logic                  w_done;
    logic [7:0]            w_load_idx;
    logic                  w_load_last;
    logic [ADDR_WIDTH-1:0] w_cur_addr;
    logic [2:0]            w_cur_size;
    logic [1:0]            w_cur_burst;
    logic [7:0]            w_cur_len;
    logic [ADDR_WIDTH-1:0] w_next_addr;
    logic [c_IDX_W-1:0]    w_word_idx;
    logic                  w_in_range;
    logic [1:0]            w_resp;
    logic [DATA_WIDTH-1:0] w_beat_data;

    assign w_ar_hs = (r_state == S_IDLE) && r_arready && arvalid;

    // In IDLE the first beat decodes straight from the AR bus so latency 0 needs no extra cycle
    always_comb begin
        w_cur_addr  = r_addr;
        w_cur_size  = r_size;
        w_cur_burst = r_burst;
        w_cur_len   = r_len;
        if (r_state == S_IDLE) begin
            w_cur_addr  = araddr;
            w_cur_size  = arsize;
            w_cur_burst = arburst;
            w_cur_len   = arlen;
        end
    end

    axi_burst_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH),
        .BASE_ADDR  (BASE_ADDR),
        .IDX_WIDTH  (c_IDX_W)
    ) u_addr_gen (
        .addr      (w_cur_addr),
        .size      (w_cur_size),
        .burst     (w_cur_burst),
        .next_addr (w_next_addr),
        .word_idx  (w_word_idx),
        .in_range  (w_in_range),
        .resp_code (w_resp)
    );

    assign w_beat_data = ((w_resp == AXI_RESP_OKAY) && w_in_range) ? r_mem[w_word_idx] : '0;
    assign w_load_last = (w_load_idx == w_cur_len);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and beat-load strobes
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_done       = 1'b0;
        w_load_idx   = 8'd0;
        case (r_state)
            S_IDLE: begin
                if (w_ar_hs) begin
                    if (c_LAT == 4'd0) begin
                        w_load       = 1'b1;
                        w_state_next = S_BURST;
                    end else begin
                        w_state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // Loading when the count reaches 1 makes rvalid appear exactly READ_LATENCY idle cycles later
                if (r_lat_cnt <= 4'd1) begin
                    w_load       = 1'b1;
                    w_state_next = S_BURST;
                end
            end
            S_BURST: begin
                if (r_rvalid && rready) begin
                    if (r_rlast) begin
                        w_done       = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_load     = 1'b1;
                        w_load_idx = r_beat_cnt + 8'd1;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Request capture, latency count and R-channel output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rlast    <= 1'b0;
            r_rresp    <= AXI_RESP_OKAY;
            r_rdata    <= '0;
            r_addr     <= '0;
            r_len      <= 8'd0;
            r_size     <= 3'd0;
            r_burst    <= AXI_BURST_FIXED;
            r_beat_cnt <= 8'd0;
            r_lat_cnt  <= 4'd0;
        end else begin
            r_arready <= (w_state_next == S_IDLE);
            if (w_ar_hs) begin
                r_addr    <= araddr;
                r_len     <= arlen;
                r_size    <= arsize;
                r_burst   <= arburst;
                r_lat_cnt <= c_LAT;
            end
            if ((r_state == S_WAIT) && !w_load) begin
                r_lat_cnt <= r_lat_cnt - 4'd1;
            end
            if (w_load) begin
                r_addr     <= w_next_addr;
                r_beat_cnt <= w_load_idx;
                r_rdata    <= w_beat_data;
                r_rresp    <= w_resp;
                r_rlast    <= w_load_last;
                r_rvalid   <= 1'b1;
            end else if (w_done) begin
                r_rvalid <= 1'b0;
                r_rlast  <= 1'b0;
            end
        end
    end

    assign arready = r_arready;
    assign rvalid  = r_rvalid;
    assign rlast   = r_rlast;
    assign rresp   = r_rresp;
    assign rdata   = r_rdata;

endmodule : axi_read_slave_mem
`default_nettype wire

// File: tb/tb_axi_read_slave_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_read_slave_mem
// Description : Scoreboard bench for axi_read_slave_mem. DUT A runs with a
//               two-cycle read latency, DUT B with zero latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_read_slave_mem;
    import axi_read_slave_mem_pkg::*;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    logic clk;
    logic rst_n;

    logic [31:0] a_araddr, b_araddr;
    logic [7:0]  a_arlen, b_arlen;
    logic [2:0]  a_arsize, b_arsize;
    logic [1:0]  a_arburst, b_arburst;
    logic        a_arvalid, b_arvalid;
    logic        a_arready, b_arready;
    logic [31:0] a_rdata, b_rdata;
    logic [1:0]  a_rresp, b_rresp;
    logic        a_rlast, b_rlast;
    logic        a_rvalid, b_rvalid;
    logic        a_rready, b_rready;

    int checks   = 0;
    int failures = 0;

    beat_t qa[$];
    beat_t qb[$];

    int cyc[2];
    int exp_first[2];
    bit pend[2];
    int beats[2];
    int hs_cyc[2];
    int last_done[2];
    bit chk_ar_after[2];
    bit bp_mode = 1'b0;
    int bp_idx  = 0;

    axi_read_slave_mem #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024),
        .BASE_ADDR(32'h0), .READ_LATENCY(2), .INIT_FILE("")
    ) dut_a (
        .clk(clk), .rst_n(rst_n),
        .araddr(a_araddr), .arlen(a_arlen), .arsize(a_arsize), .arburst(a_arburst),
        .arvalid(a_arvalid), .arready(a_arready),
        .rdata(a_rdata), .rresp(a_rresp), .rlast(a_rlast), .rvalid(a_rvalid), .rready(a_rready)
    );

    axi_read_slave_mem #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024),
        .BASE_ADDR(32'h0), .READ_LATENCY(0), .INIT_FILE("")
    ) dut_b (
        .clk(clk), .rst_n(rst_n),
        .araddr(b_araddr), .arlen(b_arlen), .arsize(b_arsize), .arburst(b_arburst),
        .arvalid(b_arvalid), .arready(b_arready),
        .rdata(b_rdata), .rresp(b_rresp), .rlast(b_rlast), .rvalid(b_rvalid), .rready(b_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push(input int d, input logic [31:0] data, input logic [1:0] resp, input logic last);
        beat_t b;
        b.data = data; b.resp = resp; b.last = last;
        if (d == 0) qa.push_back(b); else qb.push_back(b);
    endtask

    function automatic int q_size(input int d);
        return (d == 0) ? qa.size() : qb.size();
    endfunction

    task automatic set_ar(input int d, input logic v, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
        if (d == 0) begin
            a_arvalid = v; a_araddr = addr; a_arlen = len; a_arsize = size; a_arburst = burst;
        end else begin
            b_arvalid = v; b_araddr = addr; b_arlen = len; b_arsize = size; b_arburst = burst;
        end
    endtask

    function automatic logic ard(input int d);
        return (d == 0) ? a_arready : b_arready;
    endfunction

    // One monitor step per DUT on each falling edge
    task automatic mon(input int d, input logic arv, input logic ar_rdy, input logic rv, input logic rr,
                       input logic [31:0] rd, input logic [1:0] rs, input logic rl);
        string p;
        beat_t e;
        p = (d == 0) ? "A" : "B";
        cyc[d]++;
        if (chk_ar_after[d]) begin
            chk({p, ".arready_after_last"}, {31'b0, ar_rdy}, 32'd1);
            chk_ar_after[d] = 1'b0;
        end
        if (arv && ar_rdy) begin
            chk({p, ".no_overlap"}, {31'b0, rv}, 32'd0);
            pend[d]      = 1'b1;
            hs_cyc[d]    = cyc[d];
            exp_first[d] = cyc[d] + 1 + ((d == 0) ? 2 : 0);
        end
        if (pend[d]) begin
            if (rv) begin
                chk({p, ".first_rvalid_cycle"}, 32'(cyc[d]), 32'(exp_first[d]));
                pend[d] = 1'b0;
            end else if (cyc[d] >= exp_first[d]) begin
                chk({p, ".first_rvalid_missing"}, {31'b0, rv}, 32'd1);
                pend[d] = 1'b0;
            end
        end
        if (rv) begin
            chk({p, ".arready_busy"}, {31'b0, ar_rdy}, 32'd0);
            if (q_size(d) == 0) begin
                chk({p, ".unexpected_beat"}, {31'b0, rv}, 32'd0);
            end else begin
                e = (d == 0) ? qa[0] : qb[0];
                chk({p, ".rdata"}, rd, e.data);
                chk({p, ".rresp"}, {30'b0, rs}, {30'b0, e.resp});
                chk({p, ".rlast"}, {31'b0, rl}, {31'b0, e.last});
                if (rr) begin
                    if (d == 0) void'(qa.pop_front()); else void'(qb.pop_front());
                    beats[d]++;
                    if (e.last) begin
                        last_done[d]    = cyc[d];
                        chk_ar_after[d] = 1'b1;
                    end
                end
            end
        end
    endtask

    always @(negedge clk) if (rst_n) mon(0, a_arvalid, a_arready, a_rvalid, a_rready, a_rdata, a_rresp, a_rlast);
    always @(negedge clk) if (rst_n) mon(1, b_arvalid, b_arready, b_rvalid, b_rready, b_rdata, b_rresp, b_rlast);

    // R-channel ready for DUT A: always 1, or a 1,0,0 repeating pattern
    initial begin
        a_rready = 1'b1;
        forever begin
            @(posedge clk); #1;
            a_rready = bp_mode ? ((bp_idx % 3) == 0) : 1'b1;
            bp_idx++;
        end
    end

    task automatic issue(input int d, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input bit keep);
        int n;
        @(posedge clk); #1;
        set_ar(d, 1'b1, addr, len, size, burst);
        n = 0;
        do begin @(negedge clk); n++; end while (!ard(d) && n < 200);
        if (!ard(d)) chk("ar_accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        if (!keep) set_ar(d, 1'b0, 32'h0, 8'd0, 3'd0, 2'd0);
    endtask

    task automatic wait_drain(input int d);
        int n;
        n = 0;
        while (q_size(d) != 0 && n < 300) begin @(negedge clk); n++; end
        chk("drain_remaining", 32'(q_size(d)), 32'd0);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        b_rready = 1'b1;
        set_ar(0, 1'b0, 32'h0, 8'd0, 3'd0, 2'd0);
        set_ar(1, 1'b0, 32'h0, 8'd0, 3'd0, 2'd0);
        for (int i = 0; i < 1024; i++) begin
            dut_a.r_mem[i] = 32'hA000_0000 + i;
            dut_b.r_mem[i] = 32'hA000_0000 + i;
        end
        #22;
        chk("reset.arready", {31'b0, a_arready}, 32'd0);
        chk("reset.rvalid",  {31'b0, a_rvalid},  32'd0);
        chk("reset.rlast",   {31'b0, a_rlast},   32'd0);
        chk("reset.rresp",   {30'b0, a_rresp},   32'd0);
        chk("reset.rdata",   a_rdata,            32'd0);
        chk("reset.b_rvalid", {31'b0, b_rvalid}, 32'd0);
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset.arready", {31'b0, a_arready}, 32'd1);

        // 1: icache refill, rready held high
        for (int i = 0; i < 8; i++) push(0, 32'hA000_0008 + i, AXI_RESP_OKAY, i == 7);
        issue(0, 32'h20, 8'd7, AXI_SIZE_4B, AXI_BURST_INCR, 1'b0);
        wait_drain(0);

        // 2: same burst under R backpressure
        bp_mode = 1'b1;
        for (int i = 0; i < 8; i++) push(0, 32'hA000_0008 + i, AXI_RESP_OKAY, i == 7);
        issue(0, 32'h20, 8'd7, AXI_SIZE_4B, AXI_BURST_INCR, 1'b0);
        wait_drain(0);
        bp_mode = 1'b0;

        // 3: FIXED four beats, then a single beat
        for (int i = 0; i < 4; i++) push(0, 32'hA000_0004, AXI_RESP_OKAY, i == 3);
        issue(0, 32'h10, 8'd3, AXI_SIZE_4B, AXI_BURST_FIXED, 1'b0);
        wait_drain(0);
        push(0, 32'hA000_0004, AXI_RESP_OKAY, 1'b1);
        issue(0, 32'h10, 8'd0, AXI_SIZE_4B, AXI_BURST_INCR, 1'b0);
        wait_drain(0);

        // 4: burst running off the end of the memory
        push(0, 32'hA000_03FE, AXI_RESP_OKAY,   1'b0);
        push(0, 32'hA000_03FF, AXI_RESP_OKAY,   1'b0);
        push(0, 32'h0,         AXI_RESP_DECERR, 1'b0);
        push(0, 32'h0,         AXI_RESP_DECERR, 1'b1);
        issue(0, 32'hFF8, 8'd3, AXI_SIZE_4B, AXI_BURST_INCR, 1'b0);
        wait_drain(0);

        // 5: asynchronous reset in the middle of a refill
        n = beats[0] + 4;
        for (int i = 0; i < 8; i++) push(0, 32'hA000_0008 + i, AXI_RESP_OKAY, i == 7);
        issue(0, 32'h20, 8'd7, AXI_SIZE_4B, AXI_BURST_INCR, 1'b0);
        begin
            int k;
            k = 0;
            while (beats[0] < n && k < 100) begin @(negedge clk); k++; end
        end
        chk("mid_reset.beats_before", 32'(beats[0]), 32'(n));
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        chk("mid_reset.rvalid", {31'b0, a_rvalid}, 32'd0);
        chk("mid_reset.rlast",  {31'b0, a_rlast},  32'd0);
        qa.delete();
        pend[0] = 1'b0;
        chk_ar_after[0] = 1'b0;
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("after_reset.arready", {31'b0, a_arready}, 32'd1);
        for (int i = 0; i < 8; i++) push(0, 32'hA000_0010 + i, AXI_RESP_OKAY, i == 7);
        issue(0, 32'h40, 8'd7, AXI_SIZE_4B, AXI_BURST_INCR, 1'b0);
        wait_drain(0);

        // 6: zero latency, arvalid held across two bursts, then error bursts
        for (int i = 0; i < 4; i++) push(1, 32'hA000_0000 + i, AXI_RESP_OKAY, i == 3);
        issue(1, 32'h0, 8'd3, AXI_SIZE_4B, AXI_BURST_INCR, 1'b1);
        set_ar(1, 1'b1, 32'h80, 8'd1, AXI_SIZE_4B, AXI_BURST_INCR);
        push(1, 32'hA000_0020, AXI_RESP_OKAY, 1'b0);
        push(1, 32'hA000_0021, AXI_RESP_OKAY, 1'b1);
        n = 0;
        do begin @(negedge clk); n++; end while (!b_arready && n < 200);
        @(posedge clk); #1;
        set_ar(1, 1'b0, 32'h0, 8'd0, 3'd0, 2'd0);
        chk("b2b.accept_cycle", 32'(hs_cyc[1]), 32'(last_done[1] + 1));
        wait_drain(1);
        for (int i = 0; i < 4; i++) push(1, 32'h0, AXI_RESP_SLVERR, i == 3);
        issue(1, 32'h8, 8'd3, AXI_SIZE_4B, AXI_BURST_WRAP, 1'b0);
        wait_drain(1);
        push(1, 32'h0, AXI_RESP_SLVERR, 1'b0);
        push(1, 32'h0, AXI_RESP_SLVERR, 1'b1);
        issue(1, 32'h0, 8'd1, 3'd3, AXI_BURST_INCR, 1'b0);
        wait_drain(1);

        repeat (4) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_axi_read_slave_mem
`default_nettype wire
